// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU sequencer slice.
// Sequencer state encoding and default datapath widths.
package cpu_ctrl_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/exec/mem sequencer driving ProgCtr and IR.
// Handles halt, memory timeout and a saturating run cycle count.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             IsBranch,
  input  logic             IsMem,
  input  logic             IsLoad,
  input  logic             IsHalt,
  input  logic [PC_W-1:0]  Offset,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PcLoad,
  output logic             PcEn,
  output logic             BranchRel,
  output logic [PC_W-1:0]  Target,
  output logic             IrLoad,
  output logic             RegWe,
  output logic             MemReq,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [7:0] WLAST = 8'(MEM_TIMEOUT - 1);

  seq_state_t state, nxt;
  logic [7:0] wcnt;
  logic       done_q, err_q;
  logic       start_ok, mem_to, busy;

  // StartAddr is consumed by ProgCtr directly when PcLoad is high
  logic unused_addr;
  assign unused_addr = ^StartAddr;

  assign start_ok = Start && (state == IDLE || state == HALT);
  assign mem_to   = (state == MEM) && !MemReady && (wcnt == WLAST);
  assign busy     = (state == FETCH) || (state == EXEC) || (state == MEM);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, HALT: if (Start) nxt = FETCH;
      FETCH:      nxt = EXEC;
      EXEC: begin
        if (IsHalt)     nxt = HALT;
        else if (IsMem) nxt = MEM;
        else            nxt = FETCH;
      end
      MEM: begin
        if (MemReady)    nxt = FETCH;
        else if (mem_to) nxt = HALT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    PcLoad    = 1'b0;
    PcEn      = 1'b0;
    BranchRel = 1'b0;
    Target    = '0;
    IrLoad    = 1'b0;
    RegWe     = 1'b0;
    MemReq    = 1'b0;
    unique case (state)
      IDLE, HALT: PcLoad = Start && Reset_n;
      FETCH:      IrLoad = 1'b1;
      EXEC: begin
        Target = Offset;
        if (IsHalt) begin
          PcEn = 1'b0;
        end else if (IsMem) begin
          MemReq = 1'b1;
        end else if (IsBranch) begin
          PcEn      = 1'b1;
          BranchRel = Zero;
        end else begin
          PcEn  = 1'b1;
          RegWe = 1'b1;
        end
      end
      MEM: begin
        MemReq = 1'b1;
        PcEn   = MemReady;
        RegWe  = MemReady && IsLoad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wcnt <= '0;
    end else if (state == EXEC) begin
      wcnt <= '0;
    end else if (state == MEM && !MemReady) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state == EXEC && IsHalt) begin
      done_q <= 1'b1;
    end else if (mem_to) begin
      err_q <= 1'b1;
    end
  end

  assign Done  = done_q;
  assign Error = err_q;

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk  (Clk),
    .rst_n(Reset_n),
    .clr  (start_ok),
    .en   (busy),
    .q    (CycleCount)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: instruction-level model queues
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_pc_sequencer;

  localparam int TO = 15;

  typedef struct packed {
    logic       pcload;
    logic       pcen;
    logic       brel;
    logic [7:0] tgt;
    logic       irload;
    logic       regwe;
    logic       memreq;
    logic       done;
    logic       err;
    logic [3:0] cnt;
  } obs_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] StartAddr = '0;
  logic       IsBranch = 1'b0, IsMem = 1'b0, IsLoad = 1'b0, IsHalt = 1'b0;
  logic [7:0] Offset = '0;
  logic       Zero = 1'b0, MemReady = 1'b0;
  logic       PcLoad, PcEn, BranchRel, IrLoad, RegWe, MemReq, Done, Error;
  logic [7:0] Target;
  logic [3:0] CycleCount;

  int errors = 0;
  int checks = 0;

  obs_t  expq[$];
  string tagq[$];

  int   m_cnt = 0;
  logic m_done = 1'b0, m_err = 1'b0;

  pc_sequencer #(.PC_W(8), .CNT_W(4), .MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .IsBranch(IsBranch), .IsMem(IsMem), .IsLoad(IsLoad), .IsHalt(IsHalt),
    .Offset(Offset), .Zero(Zero), .MemReady(MemReady),
    .PcLoad(PcLoad), .PcEn(PcEn), .BranchRel(BranchRel), .Target(Target),
    .IrLoad(IrLoad), .RegWe(RegWe), .MemReq(MemReq), .Done(Done),
    .Error(Error), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  function automatic obs_t actual();
    return obs_t'({PcLoad, PcEn, BranchRel, Target, IrLoad, RegWe,
                   MemReq, Done, Error, CycleCount});
  endfunction

  function automatic obs_t base();
    obs_t e = '0;
    e.done = m_done;
    e.err  = m_err;
    e.cnt  = 4'(m_cnt);
    return e;
  endfunction

  function automatic void show(string tag, obs_t a, obs_t e);
    $display("FAIL %s: got pl=%b en=%b br=%b tg=%h ir=%b we=%b mr=%b dn=%b er=%b cnt=%0d want pl=%b en=%b br=%b tg=%h ir=%b we=%b mr=%b dn=%b er=%b cnt=%0d",
             tag, a.pcload, a.pcen, a.brel, a.tgt, a.irload, a.regwe,
             a.memreq, a.done, a.err, a.cnt, e.pcload, e.pcen, e.brel,
             e.tgt, e.irload, e.regwe, e.memreq, e.done, e.err, e.cnt);
  endfunction

  initial begin
    forever begin
      @(negedge Clk);
      if (expq.size() != 0) begin
        obs_t  e, a;
        string t;
        e = expq.pop_front();
        t = tagq.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
          errors++;
          show(t, a, e);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    obs_t a = actual();
    checks++;
    if (a !== '0) begin
      errors++;
      show(tag, a, '0);
    end
  endtask

  task automatic rand_in();
    IsBranch = 1'($urandom);
    IsMem    = 1'($urandom);
    IsLoad   = 1'($urandom);
    IsHalt   = 1'($urandom);
    Zero     = 1'($urandom);
    MemReady = 1'($urandom);
    Offset   = 8'($urandom);
    StartAddr = 8'($urandom);
  endtask

  task automatic cyc(input obs_t e, input string tag, input bit active);
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge Clk);
    #1;
    if (active && m_cnt < 15) m_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rand_in();
      Start = 1'b0;
      cyc(base(), "idle", 0);
    end
  endtask

  task automatic do_start(input logic [7:0] addr);
    obs_t e;
    rand_in();
    Start = 1'b1;
    StartAddr = addr;
    e = base();
    e.pcload = 1'b1;
    cyc(e, "start", 0);
    m_done = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    Start  = 1'b0;
  endtask

  // kind: 0 ALU, 1 branch, 2 memory, 3 halt
  task automatic instr(input int kind, input logic [7:0] off,
                       input logic z, input logic ld, input int waits);
    obs_t e;
    rand_in();
    Start = 1'($urandom);
    e = base();
    e.irload = 1'b1;
    cyc(e, "fetch", 1);
    rand_in();
    Start = 1'($urandom);
    Offset = off;
    Zero = z;
    IsLoad = ld;
    IsHalt = (kind == 3);
    if (kind != 3) IsMem = (kind == 2);
    if (kind < 2) IsBranch = (kind == 1);
    e = base();
    e.tgt = off;
    case (kind)
      0: begin e.pcen = 1'b1; e.regwe = 1'b1; end
      1: begin e.pcen = 1'b1; e.brel = z; end
      2: e.memreq = 1'b1;
      default: ;
    endcase
    cyc(e, kind == 3 ? "exec_halt" : "exec", 1);
    if (kind == 3) m_done = 1'b1;
    if (kind == 2) begin
      for (int i = 0; i < TO; i++) begin
        rand_in();
        Start = 1'($urandom);
        IsMem = 1'b1;
        IsLoad = ld;
        MemReady = (i == waits);
        e = base();
        e.memreq = 1'b1;
        e.pcen = MemReady;
        e.regwe = MemReady && ld;
        cyc(e, MemReady ? "mem_done" : "mem_wait", 1);
        if (i == waits) break;
      end
      if (waits >= TO) m_err = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_zero("reset_state");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(3);

    do_start(8'h10);
    repeat (3) instr(0, 8'($urandom), 1'($urandom), 1'b0, 0);
    instr(3, 8'($urandom), 1'($urandom), 1'b0, 0);
    idle(2);

    do_start(8'h20);
    instr(1, 8'hFE, 1'b1, 1'b0, 0);
    instr(1, 8'hFE, 1'b0, 1'b0, 0);
    instr(2, 8'h05, 1'b0, 1'b1, 3);
    instr(2, 8'h06, 1'b0, 1'b0, 3);
    instr(2, 8'h07, 1'b1, 1'b1, 0);
    instr(2, 8'h08, 1'b0, 1'b1, TO - 1);
    instr(3, 8'h00, 1'b0, 1'b0, 0);
    idle(1);

    do_start(8'h30);
    instr(0, 8'h01, 1'b0, 1'b0, 0);
    instr(2, 8'h09, 1'b0, 1'b1, TO);
    idle(2);
    do_start(8'h40);
    repeat (10) instr(0, 8'($urandom), 1'($urandom), 1'b0, 0);
    instr(3, 8'h00, 1'b0, 1'b0, 0);
    idle(2);

    repeat (6) begin
      do_start(8'($urandom));
      for (int k = 0; k < 8; k++) begin
        int kind, w;
        kind = int'($urandom_range(0, 2));
        w = ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(0, TO - 1));
        instr(kind, 8'($urandom), 1'($urandom), 1'($urandom), w);
        if (m_err) break;
      end
      if (!m_err) instr(3, 8'($urandom), 1'b0, 1'b0, 0);
      idle(int'($urandom_range(1, 2)));
    end

    // abort mid-MEM: fetch, exec, two waiting MEM cycles, then reset
    do_start(8'h50);
    instr(0, 8'h00, 1'b0, 1'b0, 0);
    begin
      obs_t e;
      rand_in();
      Start = 1'b0;
      e = base();
      e.irload = 1'b1;
      cyc(e, "pre_rst_fetch", 1);
      rand_in();
      IsHalt = 1'b0;
      IsMem = 1'b1;
      Offset = 8'h11;
      e = base();
      e.tgt = 8'h11;
      e.memreq = 1'b1;
      cyc(e, "pre_rst_exec", 1);
      repeat (2) begin
        rand_in();
        MemReady = 1'b0;
        e = base();
        e.memreq = 1'b1;
        cyc(e, "pre_rst_mem", 1);
      end
    end
    Start = 1'b1;
    MemReady = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk_zero("reset_mid_mem");
    @(posedge Clk);
    #1;
    chk_zero("reset_held");
    Start = 1'b0;
    Reset_n = 1'b1;
    m_cnt = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    idle(2);
    do_start(8'h60);
    instr(0, 8'h02, 1'b0, 1'b0, 0);
    instr(3, 8'h00, 1'b0, 1'b0, 0);
    idle(1);

    if (expq.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
